cu_multicycle_param: RTL and testbench
======================================

// Module: cu_multicycle_param
// PURPOSE
//  Parametrised multi-cycle control unit, successor to the fixed 4-register CU. Accepts one instruction
//  at a time via valid/ready handshake, latches it, walks DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK per type,
//  drives ALU/data-memory controls, writes back result2. Adds busy/done status, debug regfile read port,
//  optional hardwired-zero register 0. Store no longer performs register write-back.
// PARAMETERS
//  DATA_WIDTH   8  datapath / register / offset width
//  REG_COUNT    4  regfile depth, power of 2 >= 2; REG_BITS = $clog2(REG_COUNT)
//  ZERO_REG     0  1: reg 0 reads 0, writes ignored
//  INSTR_WIDTH  2+3*REG_BITS+DATA_WIDTH+4 (20 at defaults), derived localparam, not overridable
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous, active-high reset
//  instr       in   INSTR_WIDTH {type[2], dst, src1, src2, offset[DATA_WIDTH], opcode[4]}, MSB first
//  instr_valid in   1           instr present
//  instr_ready out  1           high iff state==IDLE (combinational)
//  result2     in   DATA_WIDTH  write-back data (ALU or data memory)
//  dbg_addr    in   REG_BITS    debug regfile read address
//  dbg_data    out  DATA_WIDTH  regfile[dbg_addr], combinational; 0 for reg 0 when ZERO_REG=1
//  operand1    out  DATA_WIDTH  regfile[src1]
//  operand2    out  DATA_WIDTH  std_op: regfile[src2]; loadR/storeR: regfile[dst]
//  offset      out  DATA_WIDTH  instr offset field
//  opcode      out  4           instr opcode field
//  sel1        out  1           1 = ALU result path (std_op)
//  sel3        out  1           1 = offset addressing (loadR/storeR)
//  w_r         out  1           data-memory write strobe
//  busy        out  1           state != IDLE
//  done        out  1           1-cycle pulse on instruction retirement
// BEHAVIOUR
//  Reset (async): state=IDLE; regfile[i]=i (i mod 2^DATA_WIDTH; reg0=0); operand1/operand2/offset=0;
//   opcode=4'hF; sel1=sel3=w_r=done=0. Reset mid-instruction aborts it: no write-back, no done, w_r drops.
//  Types: 00 NOP, 01 std_op, 10 loadR, 11 storeR.
//  IDLE: accept on instr_valid&&instr_ready. NOP accepted and dropped: stay IDLE, outputs unchanged,
//   no done. Else latch instr, state->DECODE; on same edge load operand1/2, offset, opcode, sel1, sel3
//   from the incoming instr and the current regfile. These hold constant until the next acceptance.
//  Sequences (one cycle each): std_op DECODE->EXECUTE->WRITE_BACK->IDLE;
//   loadR DECODE->EXECUTE->MEM_ACCESS->WRITE_BACK->IDLE; storeR DECODE->EXECUTE->MEM_ACCESS->IDLE.
//  w_r registered: high exactly during storeR MEM_ACCESS cycle, 0 elsewhere.
//  Write-back: on edge leaving WRITE_BACK, regfile[dst]<=result2 (sampled that edge); suppressed when
//   ZERO_REG=1 and dst=0.
//  done: high for first IDLE cycle after WRITE_BACK (std_op/loadR) or MEM_ACCESS (storeR).
//  New instr may be accepted in the done cycle; its operands see the just-written value (no hazard).
//  Latency, accept edge to done: std_op 4, loadR 5, storeR 4 cycles. Max throughput 1 instr/4 cycles.
//  instr/instr_valid ignored while busy; instr may change freely after acceptance.
//  State encoding: one-hot 5 bits; illegal state recovers to IDLE next edge, no write, no done.
// TESTING (defaults: DATA_WIDTH=8, REG_COUNT=4, ZERO_REG=0)
//  1 rst pulse mid-clock -> outputs at reset values immediately; dbg_data reads 0,1,2,3 for dbg_addr 0..3.
//  2 std_op 0x76002 (dst3,src1 1,src2 2,op 2), result2=0x55 in WB -> operand1=1, operand2=2, sel1=1,
//    done 4 cycles after accept; dbg_addr=3 -> 0x55.
//  3 storeR 0xD4A30 (dst1,src1 1,offset 0xA3) -> sel3=1, offset=0xA3, w_r high 1 cycle (MEM_ACCESS),
//    no WRITE_BACK state, regfile[1] still 1.
//  4 loadR 0x80100 (dst0,offset 0x10), result2=0x7E -> 5-cycle latency, regfile[0]=0x7E;
//    rerun with ZERO_REG=1 -> regfile[0]=0.
//  5 NOP 0x00000 with valid -> instr_ready stays 1, busy 0, no done. Valid held while busy -> ignored.
//  6 rst asserted in loadR MEM_ACCESS -> no write-back, no done, regfile re-initialised, next instr
//    accepted.

Source files
------------

// File: rtl/cu_multicycle_param_if.sv
// Handshake and datapath-control bundle between an instruction source
// and the multi-cycle control unit.
interface cu_multicycle_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4
);
    localparam int REG_BITS    = $clog2(REG_COUNT);
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + DATA_WIDTH + 4;

    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [DATA_WIDTH-1:0]  result2;
    logic [REG_BITS-1:0]    dbg_addr;
    logic [DATA_WIDTH-1:0]  dbg_data;
    logic [DATA_WIDTH-1:0]  operand1;
    logic [DATA_WIDTH-1:0]  operand2;
    logic [DATA_WIDTH-1:0]  offset;
    logic [3:0]             opcode;
    logic                   sel1;
    logic                   sel3;
    logic                   w_r;
    logic                   busy;
    logic                   done;

    modport master (
        output instr, instr_valid, result2, dbg_addr,
        input  instr_ready, dbg_data, operand1, operand2,
        input  offset, opcode, sel1, sel3, w_r, busy, done
    );

    modport slave (
        input  instr, instr_valid, result2, dbg_addr,
        output instr_ready, dbg_data, operand1, operand2,
        output offset, opcode, sel1, sel3, w_r, busy, done
    );
endinterface

// File: rtl/cu_multicycle_param.sv
// Parametrised multi-cycle control unit: accepts one instruction at a time,
// sequences DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK and owns the register file.
module cu_multicycle_param #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    cu_multicycle_param_if.slave bus
);
    localparam int REG_BITS    = $clog2(REG_COUNT);
    localparam int INSTR_WIDTH = 2 + 3 * REG_BITS + DATA_WIDTH + 4;

    typedef enum logic [1:0] {
        T_NOP   = 2'b00,
        T_STD   = 2'b01,
        T_LOAD  = 2'b10,
        T_STORE = 2'b11
    } itype_t;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        DECODE     = 5'b00010,
        EXECUTE    = 5'b00100,
        MEM_ACCESS = 5'b01000,
        WRITE_BACK = 5'b10000
    } state_t;

    state_t                state;
    state_t                state_n;
    itype_t                typ_q;
    logic [REG_BITS-1:0]   dst_q;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    itype_t                in_typ;
    logic [REG_BITS-1:0]   in_dst;
    logic [REG_BITS-1:0]   in_src1;
    logic [REG_BITS-1:0]   in_src2;
    logic [DATA_WIDTH-1:0] in_off;
    logic [3:0]            in_op;

    logic accept;
    logic wb_en;
    logic wr_n;
    logic done_n;

    assign in_typ  = itype_t'(bus.instr[INSTR_WIDTH-1 -: 2]);
    assign in_dst  = bus.instr[INSTR_WIDTH-3 -: REG_BITS];
    assign in_src1 = bus.instr[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign in_src2 = bus.instr[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
    assign in_off  = bus.instr[DATA_WIDTH+3 -: DATA_WIDTH];
    assign in_op   = bus.instr[3:0];

    function automatic logic [DATA_WIDTH-1:0] rd(
        input logic [REG_BITS-1:0] a
    );
        if (ZERO_REG != 0 && a == '0) return '0;
        return regs[a];
    endfunction

    assign bus.instr_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.dbg_data    = rd(bus.dbg_addr);

    // NOPs complete the handshake but never leave IDLE
    assign accept = bus.instr_valid && (state == IDLE)
                    && (in_typ != T_NOP);

    assign wb_en  = (state == WRITE_BACK)
                    && !(ZERO_REG != 0 && dst_q == '0);
    assign wr_n   = (state == EXECUTE) && (typ_q == T_STORE);
    assign done_n = (state == WRITE_BACK)
                    || (state == MEM_ACCESS && typ_q == T_STORE);

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:       state_n = accept ? DECODE : IDLE;
            DECODE:     state_n = EXECUTE;
            EXECUTE:    state_n = (typ_q == T_STD) ? WRITE_BACK
                                                   : MEM_ACCESS;
            MEM_ACCESS: state_n = (typ_q == T_LOAD) ? WRITE_BACK
                                                    : IDLE;
            WRITE_BACK: state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            typ_q        <= T_NOP;
            dst_q        <= '0;
            bus.operand1 <= '0;
            bus.operand2 <= '0;
            bus.offset   <= '0;
            bus.opcode   <= 4'hF;
            bus.sel1     <= 1'b0;
            bus.sel3     <= 1'b0;
            bus.w_r      <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.w_r  <= wr_n;
            bus.done <= done_n;
            if (accept) begin
                typ_q        <= in_typ;
                dst_q        <= in_dst;
                bus.operand1 <= rd(in_src1);
                bus.operand2 <= (in_typ == T_STD) ? rd(in_src2)
                                                  : rd(in_dst);
                bus.offset   <= in_off;
                bus.opcode   <= in_op;
                bus.sel1     <= (in_typ == T_STD);
                bus.sel3     <= in_typ[1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= DATA_WIDTH'(i);
        end else if (wb_en) begin
            regs[dst_q] <= bus.result2;
        end
    end
endmodule

// File: tb/tb_cu_multicycle_param.sv
// Self-checking bench: two units (ZERO_REG=0 and ZERO_REG=1) driven in lockstep
// and compared against an instruction-level model of the register file.
module tb_cu_multicycle_param;
    localparam int DW = 8;
    localparam int RC = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    cu_multicycle_param_if #(.DATA_WIDTH(DW), .REG_COUNT(RC)) b0 ();
    cu_multicycle_param_if #(.DATA_WIDTH(DW), .REG_COUNT(RC)) b1 ();

    assign b1.instr       = b0.instr;
    assign b1.instr_valid = b0.instr_valid;
    assign b1.result2     = b0.result2;
    assign b1.dbg_addr    = b0.dbg_addr;

    cu_multicycle_param #(
        .DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    cu_multicycle_param #(
        .DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(1)
    ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    logic [7:0] o_op1 [2];
    logic [7:0] o_op2 [2];
    logic [7:0] o_off [2];
    logic [3:0] o_opc [2];
    logic [7:0] o_dbg [2];
    logic       o_s1  [2];
    logic       o_s3  [2];
    logic       o_wr  [2];
    logic       o_dn  [2];
    logic       o_bsy [2];
    logic       o_rdy [2];

    assign o_op1[0] = b0.operand1;
    assign o_op1[1] = b1.operand1;
    assign o_op2[0] = b0.operand2;
    assign o_op2[1] = b1.operand2;
    assign o_off[0] = b0.offset;
    assign o_off[1] = b1.offset;
    assign o_opc[0] = b0.opcode;
    assign o_opc[1] = b1.opcode;
    assign o_dbg[0] = b0.dbg_data;
    assign o_dbg[1] = b1.dbg_data;
    assign o_s1[0]  = b0.sel1;
    assign o_s1[1]  = b1.sel1;
    assign o_s3[0]  = b0.sel3;
    assign o_s3[1]  = b1.sel3;
    assign o_wr[0]  = b0.w_r;
    assign o_wr[1]  = b1.w_r;
    assign o_dn[0]  = b0.done;
    assign o_dn[1]  = b1.done;
    assign o_bsy[0] = b0.busy;
    assign o_bsy[1] = b1.busy;
    assign o_rdy[0] = b0.instr_ready;
    assign o_rdy[1] = b1.instr_ready;

    // Reference model: architectural registers and last latched controls
    logic [7:0] m_regs [2][RC];
    logic [7:0] e_op1 [2];
    logic [7:0] e_op2 [2];
    logic [7:0] e_off [2];
    logic [3:0] e_opc [2];
    logic       e_s1  [2];
    logic       e_s3  [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s_u%0d", s, k);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < RC; i++) m_regs[k][i] = 8'(i);
            e_op1[k] = 8'h00;
            e_op2[k] = 8'h00;
            e_off[k] = 8'h00;
            e_opc[k] = 4'hF;
            e_s1[k]  = 1'b0;
            e_s3[k]  = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(tg({tag, "_op1"}, k), 32'(o_op1[k]), 32'(e_op1[k]));
            chk(tg({tag, "_op2"}, k), 32'(o_op2[k]), 32'(e_op2[k]));
            chk(tg({tag, "_off"}, k), 32'(o_off[k]), 32'(e_off[k]));
            chk(tg({tag, "_opc"}, k), 32'(o_opc[k]), 32'(e_opc[k]));
            chk(tg({tag, "_sel1"}, k), 32'(o_s1[k]), 32'(e_s1[k]));
            chk(tg({tag, "_sel3"}, k), 32'(o_s3[k]), 32'(e_s3[k]));
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int a = 0; a < RC; a++) begin
            b0.dbg_addr = 2'(a);
            #1;
            for (int k = 0; k < 2; k++)
                chk(tg($sformatf("%s_r%0d", tag, a), k),
                    32'(o_dbg[k]), 32'(m_regs[k][a]));
        end
    endtask

    task automatic rst_checks(input string tag);
        m_reset();
        check_outs(tag);
        for (int k = 0; k < 2; k++) begin
            chk(tg({tag, "_wr"}, k), 32'(o_wr[k]), 0);
            chk(tg({tag, "_done"}, k), 32'(o_dn[k]), 0);
            chk(tg({tag, "_busy"}, k), 32'(o_bsy[k]), 0);
            chk(tg({tag, "_rdy"}, k), 32'(o_rdy[k]), 1);
        end
        chk_regs(tag);
    endtask

    task automatic run_instr(input string tag, input logic [19:0] ins,
                             input logic [7:0] r2);
        logic [1:0] t;
        logic [1:0] dst;
        int lat_exp;
        int wb_c;
        int lat [2];
        int wrn [2];
        int wra [2];
        logic [1:0] got;
        t = ins[19:18];
        dst = ins[17:16];
        @(negedge clk);
        b0.instr = ins;
        b0.instr_valid = 1'b1;
        b0.result2 = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            chk(tg({tag, "_rdy0"}, k), 32'(o_rdy[k]), 1);
            chk(tg({tag, "_bsy0"}, k), 32'(o_bsy[k]), 0);
            if (t != 2'b00) begin
                e_op1[k] = m_regs[k][ins[15:14]];
                e_op2[k] = (t == 2'b01) ? m_regs[k][ins[13:12]]
                                        : m_regs[k][dst];
                e_off[k] = ins[11:4];
                e_opc[k] = ins[3:0];
                e_s1[k]  = (t == 2'b01);
                e_s3[k]  = t[1];
            end
        end
        @(posedge clk);
        #1;
        b0.instr_valid = 1'b0;
        b0.instr = 20'($urandom);
        check_outs({tag, "_acc"});
        for (int k = 0; k < 2; k++) begin
            chk(tg({tag, "_dn1"}, k), 32'(o_dn[k]), 0);
            chk(tg({tag, "_bsy1"}, k), 32'(o_bsy[k]), 32'(t != 2'b00));
        end
        if (t == 2'b00) return;
        lat_exp = (t == 2'b10) ? 5 : 4;
        wb_c = (t == 2'b01) ? 4 : ((t == 2'b10) ? 5 : 0);
        got = 2'b00;
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0;
            wrn[k] = 0;
            wra[k] = 0;
        end
        for (int c = 2; c <= 9 && got != 2'b11; c++) begin
            b0.instr_valid = 1'($urandom);
            b0.instr = 20'($urandom);
            b0.result2 = (c == wb_c) ? r2 : 8'($urandom);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!got[k]) begin
                    if (o_wr[k]) begin
                        wrn[k]++;
                        wra[k] = c;
                    end
                    if (o_dn[k]) begin
                        got[k] = 1'b1;
                        lat[k] = c;
                        chk(tg({tag, "_rdyd"}, k), 32'(o_rdy[k]), 1);
                    end else begin
                        chk(tg({tag, "_bsy"}, k), 32'(o_bsy[k]), 1);
                    end
                end
            end
        end
        b0.instr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(tg({tag, "_lat"}, k), 32'(lat[k]), 32'(lat_exp));
            chk(tg({tag, "_wrn"}, k), 32'(wrn[k]), 32'(t == 2'b11));
            if (t == 2'b11)
                chk(tg({tag, "_wrat"}, k), 32'(wra[k]), 3);
            if (t != 2'b11 && !(k == 1 && dst == 2'd0))
                m_regs[k][dst] = r2;
        end
        check_outs({tag, "_hold"});
        chk_regs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        b0.instr = '0;
        b0.instr_valid = 1'b0;
        b0.result2 = '0;
        b0.dbg_addr = '0;
        #2;
        rst_checks("rst_init");
        @(negedge clk);
        rst = 1'b0;

        run_instr("std", 20'h76002, 8'h55);
        run_instr("store", 20'hD4A30, 8'h11);
        run_instr("load0", 20'h80100, 8'h7E);
        run_instr("nop", 20'h00000, 8'h22);

        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        rst_checks("rst_mid");
        rst = 1'b0;

        run_instr("std2", 20'h5B0C1, 8'hC3);

        @(negedge clk);
        b0.instr = 20'hA4335;
        b0.instr_valid = 1'b1;
        e_op1[0] = m_regs[0][1];
        @(posedge clk);
        #1;
        b0.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        b0.result2 = 8'h99;
        chk(tg("abort_bsy", 0), 32'(o_bsy[0]), 1);
        chk(tg("abort_op1", 0), 32'(o_op1[0]), 32'(e_op1[0]));
        rst = 1'b1;
        #1;
        rst_checks("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk(tg("abort_dn", k), 32'(o_dn[k]), 0);
                chk(tg("abort_bsy2", k), 32'(o_bsy[k]), 0);
            end
        end
        chk_regs("abort_regs");
        run_instr("after_abort", 20'h6D004, 8'h3C);

        for (int n = 0; n < 40; n++)
            run_instr($sformatf("rnd%0d", n), 20'($urandom),
                      8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
